sc_rival_spawn_scheduler: RTL

//  Sequences rival-car spawning for the road playfield. Level-dependent tick interval

---
 rtl/sc_rival_spawn_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sc_rival_spawn_scheduler.sv
// Rival-car spawn sequencer: level-paced interval, random lane pick, round-robin
// slot allocation and a valid/ready spawn handshake to the sprite datapath.
module sc_rival_spawn_scheduler #(
    parameter int unsigned NSLOTS = 4,
    parameter int unsigned LANES  = 6,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned INT_L1 = 32,
    parameter int unsigned INT_L2 = 20,
    parameter int unsigned INT_L3 = 12
) (
    input  logic                              SC_STATEMACHINE_RANDOM_CLOCK_50,
    input  logic                              SC_STATEMACHINE_RANDOM_RESET_InLow,
    input  logic                              start_InLow,
    input  logic [1:0]                        level,
    input  logic                              tick,
    input  logic [7:0]                        rand_value,
    input  logic [NSLOTS-1:0]                 slot_busy,
    output logic                              rand_req,
    output logic                              spawn_valid,
    input  logic                              spawn_ready,
    output logic [$clog2(NSLOTS)-1:0]         spawn_slot,
    output logic [2:0]                        spawn_lane,
    output logic                              spawn_skip,
    output logic                              active
);

    localparam int unsigned SW = $clog2(NSLOTS);

    typedef enum logic [2:0] {IDLE, WAIT, REQ, ALLOC, ISSUE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [SW-1:0]     rr_ptr;

    logic [2:0]        lane_c;
    logic              found_c;
    logic [SW-1:0]     grant_c;
    logic              unused_rand_bits;

    // Ticks per spawn interval for the current level; 00 never reaches a reload.
    function automatic logic [CNT_W-1:0] reload_value(input logic [1:0] lvl);
        case (lvl)
            2'b01:   reload_value = CNT_W'(INT_L1);
            2'b10:   reload_value = CNT_W'(INT_L2);
            default: reload_value = CNT_W'(INT_L3);
        endcase
    endfunction

    // Fold the 3-bit random field into 0..LANES-1.
    always_comb begin
        logic [3:0] raw;
        raw    = {1'b0, rand_value[2:0]};
        lane_c = rand_value[2:0];
        if (raw >= 4'(LANES)) begin
            lane_c = 3'(raw - 4'(LANES));
        end
    end

    // Upper random bits are not needed for lane selection.
    assign unused_rand_bits = ^rand_value[7:3];

    // First free slot starting at rr_ptr, wrapping modulo NSLOTS.
    always_comb begin
        logic [SW-1:0] idx;
        found_c = 1'b0;
        grant_c = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            idx = rr_ptr + SW'(i);
            if (!found_c && !slot_busy[idx]) begin
                found_c = 1'b1;
                grant_c = idx;
            end
        end
    end

    always_ff @(posedge SC_STATEMACHINE_RANDOM_CLOCK_50 or negedge SC_STATEMACHINE_RANDOM_RESET_InLow) begin
        if (!SC_STATEMACHINE_RANDOM_RESET_InLow) begin
            state      <= IDLE;
            counter    <= '0;
            rr_ptr     <= '0;
            spawn_slot <= '0;
            spawn_lane <= '0;
            spawn_skip <= 1'b0;
        end else begin
            spawn_skip <= 1'b0;
            if (level == 2'b00) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!start_InLow) begin
                            counter <= reload_value(level);
                            state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (tick) begin
                            if (counter <= CNT_W'(1)) begin
                                counter <= '0;
                                state   <= REQ;
                            end else begin
                                counter <= counter - CNT_W'(1);
                            end
                        end
                    end
                    REQ: state <= ALLOC;
                    ALLOC: begin
                        if (found_c) begin
                            spawn_slot <= grant_c;
                            spawn_lane <= lane_c;
                            state      <= ISSUE;
                        end else begin
                            spawn_skip <= 1'b1;
                            counter    <= reload_value(level);
                            state      <= WAIT;
                        end
                    end
                    ISSUE: begin
                        if (spawn_ready) begin
                            rr_ptr  <= spawn_slot + SW'(1);
                            counter <= reload_value(level);
                            state   <= WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Handshake and status outputs decode directly from the state register.
    assign rand_req    = (state == REQ);
    assign spawn_valid = (state == ISSUE);
    assign active      = (state != IDLE);

endmodule
